l2_l1_responder: RTL and testbench

//  L2-side responder for the L1D miss interface. Serves one L1 request at a time:

---
 rtl/l2_l1_responder.sv | 126 ++++++++++++
 tb/tb_l2_l1_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_l1_responder.sv
// L2-side responder for the L1D miss interface: one outstanding writeback or refill,
// served from a line-granular array after LATENCY cycles. Optional stats: L2_RESP_STATS_EN.
module l2_l1_responder #(
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5,
  parameter int MEM_LINES   = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l1_l2_req_valid,
  output logic                 l1_l2_req_ready,
  input  logic                 l1_l2_req_wb,
  input  logic [31:0]          l1_l2_req_addr,
  input  logic [LINE_BITS-1:0] l1_l2_req_wdata,
  output logic                 l2_l1_wb_done,
  output logic                 l2_l1_refill_done,
  output logic [LINE_BITS-1:0] l2_l1_rdata
`ifdef L2_RESP_STATS_EN
  ,
  output logic [31:0]          stat_refill_cnt,
  output logic [31:0]          stat_wb_cnt
`endif
);

  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_M1   = CW'(LATENCY - 1);
  localparam logic [31:0]   IDX_MASK = 32'(MEM_LINES - 1) << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wb_q;
  logic [IW-1:0]        idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 wb_done_q, refill_done_q;
  logic                 accept, fire;

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  // Offset and upper address bits are dropped on purpose: lines alias modulo MEM_LINES.
  logic unused_addr;
  assign unused_addr = ^(l1_l2_req_addr & ~IDX_MASK);

  assign l1_l2_req_ready = !rst && (state_q == IDLE || state_q == DONE);
  assign accept          = l1_l2_req_valid && l1_l2_req_ready;
  assign fire            = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      wb_done_q     <= 1'b0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_done_q     <= fire && wb_q;
      refill_done_q <= fire && !wb_q;
      if (fire && !wb_q) rdata_q <= mem[idx_q];
    end
  end

  // NOTE: the request capture and the array carry no reset; they are only consumed
  // after an accept has loaded them, and an array cannot be reset in one cycle anyway.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_q    <= l1_l2_req_wb;
      idx_q   <= l1_l2_req_addr[OFFSET_BITS +: IW];
      wdata_q <= l1_l2_req_wdata;
    end
    if (fire && wb_q) mem[idx_q] <= wdata_q;
  end

  assign l2_l1_wb_done     = wb_done_q;
  assign l2_l1_refill_done = refill_done_q;
  assign l2_l1_rdata       = rdata_q;

`ifdef L2_RESP_STATS_EN
  logic [31:0] stat_refill_q, stat_wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_refill_q <= '0;
      stat_wb_q     <= '0;
    end else begin
      if (refill_done_q) stat_refill_q <= stat_refill_q + 32'd1;
      if (wb_done_q)     stat_wb_q     <= stat_wb_q + 32'd1;
    end
  end

  assign stat_refill_cnt = stat_refill_q;
  assign stat_wb_cnt     = stat_wb_q;
`endif

endmodule

// File: tb/tb_l2_l1_responder.sv
// Randomized self-checking bench for l2_l1_responder against a line-array reference model.
// Build with L2_RESP_STATS_EN defined to also check the statistics counters.
module tb_l2_l1_responder;

  localparam int LB          = 256;
  localparam int OFFSET_BITS = 5;
  localparam int MEM_LINES   = 1024;
  localparam int LATENCY     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, ready, wb;
  logic [31:0]   addr;
  logic [LB-1:0] wdata, rdata;
  logic          wb_done, refill_done;
`ifdef L2_RESP_STATS_EN
  logic [31:0]   stat_refill_cnt, stat_wb_cnt;
`endif

  l2_l1_responder #(
    .LINE_BITS(LB), .OFFSET_BITS(OFFSET_BITS), .MEM_LINES(MEM_LINES), .LATENCY(LATENCY)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .l1_l2_req_valid  (valid),
    .l1_l2_req_ready  (ready),
    .l1_l2_req_wb     (wb),
    .l1_l2_req_addr   (addr),
    .l1_l2_req_wdata  (wdata),
    .l2_l1_wb_done    (wb_done),
    .l2_l1_refill_done(refill_done),
    .l2_l1_rdata      (rdata)
`ifdef L2_RESP_STATS_EN
    ,
    .stat_refill_cnt  (stat_refill_cnt),
    .stat_wb_cnt      (stat_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference model: contents of every line ever written, plus the expected rdata register.
  logic [LB-1:0] model_mem [int];
  logic [LB-1:0] exp_rdata;
  bit            exp_known;
  int            exp_refills, exp_wbs;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / (32'd1 << OFFSET_BITS)) % MEM_LINES);
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] rand_addr_for(input int line);
    logic [31:0] a;
    a = $urandom;
    a = a - (a % 32'd32768) + 32'(line) * 32'd32 + 32'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic model_reset();
    exp_rdata   = '0;
    exp_known   = 1'b1;
    exp_refills = 0;
    exp_wbs     = 0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request: wait for acceptance, then check latency, pulse kind, busy ready and rdata.
  task automatic transact(input bit is_wb, input logic [31:0] a, input logic [LB-1:0] d);
    int  n;
    bit  got;
    int  idx;
    @(negedge clk);
    valid = 1'b1; wb = is_wb; addr = a; wdata = d;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL accept_timeout: ready=%b required=1", ready);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= LATENCY + 4 && !got; k++) begin
      @(posedge clk);
      #1;
      if (wb_done === 1'b1 || refill_done === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (k != LATENCY) begin
          errs++;
          $display("FAIL latency: got %0d cycles required %0d", k, LATENCY);
        end
        vectors++;
        if (wb_done !== is_wb || refill_done !== !is_wb) begin
          errs++;
          $display("FAIL pulse_kind: wb_done=%b refill_done=%b required %b/%b",
                   wb_done, refill_done, is_wb, !is_wb);
        end
      end else begin
        vectors++;
        if (ready !== 1'b0) begin
          errs++;
          $display("FAIL busy_ready: ready=%b required=0 at cycle %0d", ready, k);
        end
      end
    end
    vectors++;
    if (!got) begin
      errs++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", LATENCY + 4);
    end
    idx = line_of(a);
    if (is_wb) begin
      model_mem[idx] = d;
      exp_wbs++;
    end else begin
      exp_known = model_mem.exists(idx);
      if (exp_known) exp_rdata = model_mem[idx];
      exp_refills++;
    end
    if (got && exp_known) begin
      vectors++;
      if (rdata !== exp_rdata) begin
        errs++;
        $display("FAIL rdata (%s line %0d): got %h required %h",
                 is_wb ? "wb" : "refill", idx, rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b0 || wb_done !== 1'b0 || refill_done !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctrl: ready=%b wb_done=%b refill_done=%b required 0/0/0",
               ready, wb_done, refill_done);
    end
    vectors++;
    if (rdata !== '0) begin
      errs++;
      $display("FAIL reset_rdata: got %h required 0", rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_ready: ready=%b required=1", ready);
    end
  endtask

  task automatic test_wb_refill();
    transact(1'b1, 32'h0000_0040, {8{32'hDEADBEEF}});
    transact(1'b0, 32'h0000_0040, '0);
  endtask

  task automatic test_alias();
    transact(1'b1, 32'h0000_0020, rand_line());
    transact(1'b0, 32'h0000_003C, '0);
    transact(1'b0, 32'h0000_8020, '0);
  endtask

  // Valid held high continuously: accepts only in IDLE/DONE, pulses one cycle wide.
  task automatic test_back_to_back();
    bit exp_ready, exp_pulse;
    idle(2);
    @(negedge clk);
    valid = 1'b1; wb = 1'b0; addr = 32'h0000_0040; wdata = '0;
    for (int k = 0; k < 2 * (LATENCY + 1); k++) begin
      exp_ready = (k % (LATENCY + 1)) == 0;
      vectors++;
      if (ready !== exp_ready) begin
        errs++;
        $display("FAIL hold_ready: cycle %0d ready=%b required=%b", k, ready, exp_ready);
      end
      @(posedge clk);
      #1;
      exp_pulse = (k % (LATENCY + 1)) == LATENCY;
      vectors++;
      if (refill_done !== exp_pulse || wb_done !== 1'b0) begin
        errs++;
        $display("FAIL hold_pulse: cycle %0d refill_done=%b wb_done=%b required %b/0",
                 k, refill_done, wb_done, exp_pulse);
      end
      if (exp_pulse) begin
        exp_rdata = model_mem[line_of(32'h0000_0040)];
        exp_known = 1'b1;
        exp_refills++;
        vectors++;
        if (rdata !== exp_rdata) begin
          errs++;
          $display("FAIL hold_rdata: got %h required %h", rdata, exp_rdata);
        end
      end
      if (k == 2 * (LATENCY + 1) - 1) valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (refill_done !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL pulse_width: refill_done=%b ready=%b required 0/1", refill_done, ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [LB-1:0] old_line;
    old_line = rand_line();
    transact(1'b1, 32'h0000_0080, old_line);
    @(negedge clk);
    valid = 1'b1; wb = 1'b1; addr = 32'h0000_0080; wdata = ~old_line;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL midbusy_reset_ready: ready=%b required=0", ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < LATENCY + 4; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (wb_done !== 1'b0 || refill_done !== 1'b0) begin
        errs++;
        $display("FAIL aborted_pulse: cycle %0d wb_done=%b refill_done=%b required 0/0",
                 k, wb_done, refill_done);
      end
    end
    transact(1'b0, 32'h0000_0080, '0);
  endtask

  task automatic test_random();
    int lines [8] = '{3, 17, 100, 511, 512, 700, 1000, 1023};
    int ln;
    foreach (lines[i]) transact(1'b1, rand_addr_for(lines[i]), rand_line());
    for (int t = 0; t < 40; t++) begin
      ln = lines[$urandom_range(0, 7)];
      transact(1'($urandom_range(0, 1)), rand_addr_for(ln), rand_line());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

`ifdef L2_RESP_STATS_EN
  task automatic test_stats();
    idle(2);
    vectors++;
    if (stat_refill_cnt !== 32'(exp_refills) || stat_wb_cnt !== 32'(exp_wbs)) begin
      errs++;
      $display("FAIL stats: refill=%0d wb=%0d required %0d/%0d",
               stat_refill_cnt, stat_wb_cnt, exp_refills, exp_wbs);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; wb = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_wb_refill();
    test_reset();
    test_alias();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
`ifdef L2_RESP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
